// File: rtl/digit_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : digit_scan_ctrl                                            |
// | Description : Time-multiplexed scan controller for a 4-digit 7-segment   |
// |               display. Cycles through digits 0..3, lighting each for     |
// |               DWELL cycles followed by GAP all-off cycles. A shadow      |
// |               register accepts new values at any time; they are moved    |
// |               to the displayed (active) register only at frame start,    |
// |               so a frame never shows a mix of old and new nibbles.       |
// |                                                                          |
// | Parameters  : DWELL  cycles each digit is lit (1..65535)                 |
// |               GAP    all-off cycles after each dwell (0..65535)          |
// | Ports       : clk          system clock, rising edge                     |
// |               rst          synchronous active-high reset                 |
// |               en           scan enable (0 -> IDLE, display dark)         |
// |               value[15:0]  four hex nibbles, nibble k -> digit k         |
// |               load         strobe, captures value into shadow            |
// |               dp_mask[3:0] decimal-point request per digit              |
// |               nib[3:0]     nibble for the shared segment decoder         |
// |               sel[3:0]     one-hot digit enable, active-high             |
// |               dp           decimal point for the lit digit               |
// |               frame_start  pulse on first dwell cycle of digit 0         |
// |               pending      shadow holds a value not yet displayed        |
// | Options     : DIGI_LZ_BLANK_EN  when defined, leading-zero digits (k>0)  |
// |               stay dark during their dwell; timing is unchanged.         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module digit_scan_ctrl #(
  parameter int unsigned DWELL = 50000,
  parameter int unsigned GAP   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  nib,
  output logic [3:0]  sel,
  output logic        dp,
  output logic        frame_start,
  output logic        pending
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [15:0] C_DWELL_LAST = 16'(DWELL - 1);
  localparam logic        C_GAP_ZERO   = (GAP == 0);
  localparam logic [15:0] C_GAP_LAST   = C_GAP_ZERO ? 16'd0 : 16'(GAP - 1);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] active_q, active_d;
  logic [15:0] shadow_q, shadow_d;
  logic        pending_q, pending_d;
  logic [3:0]  nib_q, nib_d;
  logic [3:0]  sel_q, sel_d;
  logic        dp_q, dp_d;
  logic        fs_q, fs_d;
  logic        enter_frame;   // this edge enters DWELL with idx=0
  logic        lz_blank;      // digit about to be shown is a leading zero

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    active_d    = active_q;
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    enter_frame = 1'b0;
    lz_blank    = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
      idx_d   = 2'd0;
      cnt_d   = 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_DWELL;
          idx_d       = 2'd0;
          cnt_d       = 16'd0;
          enter_frame = 1'b1;
        end
        ST_DWELL: begin
          if (cnt_q == C_DWELL_LAST) begin
            cnt_d = 16'd0;
            if (C_GAP_ZERO) begin
              // No gap: step straight to the next digit's dwell.
              idx_d       = idx_q + 2'd1;
              enter_frame = (idx_q == 2'd3);
            end else begin
              state_d = ST_GAP;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_GAP: begin
          if (cnt_q == C_GAP_LAST) begin
            state_d     = ST_DWELL;
            cnt_d       = 16'd0;
            idx_d       = idx_q + 2'd1;
            enter_frame = (idx_q == 2'd3);
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
          cnt_d   = 16'd0;
        end
      endcase
    end

    // Shadow capture; the last load in a frame wins.
    if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end

    // Frame boundary: a coincident load bypasses the shadow so it is
    // displayed immediately and nothing is left pending.
    if (enter_frame) begin
      if (load) begin
        active_d  = value;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end

`ifdef DIGI_LZ_BLANK_EN
    case (idx_d)
      2'd1:    lz_blank = (active_d[15:4]  == 12'd0);
      2'd2:    lz_blank = (active_d[15:8]  == 8'd0);
      2'd3:    lz_blank = (active_d[15:12] == 4'd0);
      default: lz_blank = 1'b0;
    endcase
`endif

    // Outputs are computed from next-state values so the registered
    // outputs line up with the registered state.
    nib_d = active_d[{idx_d, 2'b00} +: 4];
    sel_d = 4'd0;
    dp_d  = 1'b0;
    if ((state_d == ST_DWELL) && !lz_blank) begin
      sel_d = 4'b0001 << idx_d;
      dp_d  = dp_mask[idx_d];
    end
    fs_d = enter_frame;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      cnt_q     <= 16'd0;
      active_q  <= 16'd0;
      shadow_q  <= 16'd0;
      pending_q <= 1'b0;
      nib_q     <= 4'd0;
      sel_q     <= 4'd0;
      dp_q      <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      nib_q     <= nib_d;
      sel_q     <= sel_d;
      dp_q      <= dp_d;
      fs_q      <= fs_d;
    end
  end

  assign nib         = nib_q;
  assign sel         = sel_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;
  assign pending     = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_digit_scan_ctrl                                         |
// | Description : Directed self-checking bench for digit_scan_ctrl.          |
// |               u_dut uses DWELL=4 GAP=2; u_dut_z uses DWELL=4 GAP=0.      |
// |               Expectations follow DIGI_LZ_BLANK_EN if it is defined.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_digit_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, load, en_z, load_z;
  logic [15:0] value, value_z;
  logic [3:0]  dp_mask;
  logic [3:0]  nib, sel, nib_z, sel_z;
  logic        dp, frame_start, pending, dp_z, frame_start_z, pending_z;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  digit_scan_ctrl #(.DWELL(4), .GAP(2)) u_dut (
    .clk(clk), .rst(rst), .en(en), .value(value), .load(load),
    .dp_mask(dp_mask), .nib(nib), .sel(sel), .dp(dp),
    .frame_start(frame_start), .pending(pending)
  );

  digit_scan_ctrl #(.DWELL(4), .GAP(0)) u_dut_z (
    .clk(clk), .rst(rst), .en(en_z), .value(value_z), .load(load_z),
    .dp_mask(dp_mask), .nib(nib_z), .sel(sel_z), .dp(dp_z),
    .frame_start(frame_start_z), .pending(pending_z)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {frame_start, sel, nib, dp} at cycle c of a frame (c=0 is the
  // first dwell cycle of digit 0) while showing value v.
  function automatic logic [9:0] model(input logic [15:0] v, input int c,
                                       input int dw, input int gp, input logic [3:0] m);
    int         per;
    int         seg;
    int         pos;
    logic       lit;
    logic       blank;
    logic       fs;
    logic [3:0] s;
    logic [3:0] n;
    logic       d;
    per   = dw + gp;
    seg   = (c / per) % 4;
    pos   = c % per;
    lit   = (pos < dw);
    blank = 1'b0;
`ifdef DIGI_LZ_BLANK_EN
    blank = (seg > 0) && ((v >> (4 * seg)) == 16'd0);
`endif
    fs = ((c % (4 * per)) == 0);
    n  = v[4*seg +: 4];
    s  = (lit && !blank) ? (4'b0001 << seg) : 4'd0;
    d  = (lit && !blank) ? m[seg] : 1'b0;
    return {fs, s, n, d};
  endfunction

  // Check n cycles of the GAP=2 instance; optionally load ld_val at cycle ld_at.
  task automatic run_frame(input logic [15:0] v, input int n, input int ld_at,
                           input logic [15:0] ld_val);
    for (int c = 0; c < n; c++) begin
      check("scan", {frame_start, sel, nib, dp}, model(v, c, 4, 2, dp_mask));
      check("pending", pending, (c > ld_at));
      load = (c == ld_at);
      if (c == ld_at) value = ld_val;
      tick();
    end
    load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; value = 16'h0;
    en_z = 1'b0; load_z = 1'b0; value_z = 16'h0;
    dp_mask = 4'b1010;
    tick();
    tick();
    check("rst_out", {frame_start, sel, nib, dp}, 10'd0);
    check("rst_pending", pending, 1'b0);
    check("rst_out_z", {frame_start_z, sel_z, nib_z, dp_z}, 10'd0);

    // Enable with a load coinciding with the first frame entry.
    rst = 1'b0; en = 1'b1; load = 1'b1; value = 16'h1234;
    tick();
    load = 1'b0;
    run_frame(16'h1234, 24, 99, 16'h0);

    // Load mid-frame: held in shadow until next frame start.
    run_frame(16'h1234, 24, 6, 16'hABCD);
    run_frame(16'hABCD, 12, 99, 16'h0);

    // Drop enable during digit 2 dwell.
    check("d2_dwell", {frame_start, sel, nib, dp}, model(16'hABCD, 12, 4, 2, dp_mask));
    en = 1'b0;
    tick();
    check("idle", {frame_start, sel, nib, dp}, {1'b0, 4'd0, 4'hD, 1'b0});
    tick();
    check("idle2", {frame_start, sel, nib, dp}, {1'b0, 4'd0, 4'hD, 1'b0});
    en = 1'b1;
    tick();
    run_frame(16'hABCD, 24, 99, 16'h0);

    // Load 0x00FF, then reset mid-gap.
    run_frame(16'hABCD, 5, 0, 16'h00FF);
    check("gap", {frame_start, sel, nib, dp}, model(16'hABCD, 5, 4, 2, dp_mask));
    rst = 1'b1;
    tick();
    check("rst_mid_out", {frame_start, sel, nib, dp}, 10'd0);
    check("rst_mid_pending", pending, 1'b0);
    rst = 1'b0;
    tick();
    run_frame(16'h0000, 24, 0, 16'h0050);
    run_frame(16'h0050, 24, 99, 16'h0);

    // GAP=0 instance: no dark cycles, 16-cycle frame.
    en_z = 1'b1; load_z = 1'b1; value_z = 16'h4321;
    tick();
    load_z = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      check("gap0", {frame_start_z, sel_z, nib_z, dp_z}, model(16'h4321, c, 4, 0, dp_mask));
      tick();
    end
    check("gap0_pending", pending_z, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/digit_scan_ctrl.md
DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL, default 50000, cycles each digit is lit (1..65535).
REQ-002 SHALL have parameter GAP, default 16, all-digits-off cycles after each dwell (0..65535).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  scan enable.
REQ-006 SHALL have port value  input  16  four hex nibbles; nibble k drives digit k (digit 0 = least significant).
REQ-007 SHALL have port load  input  1  single-cycle strobe; captures value into the shadow register.
REQ-008 SHALL have port dp_mask  input  4  decimal-point request per digit.
REQ-009 SHALL have port nib  output  4  nibble for the shared 7-segment decoder input.
REQ-010 SHALL have port sel  output  4  one-hot digit enable, active-high; 0 = all off.
REQ-011 SHALL have port dp  output  1  decimal point for the lit digit.
REQ-012 SHALL have port frame_start  output  1  one-cycle pulse on the first dwell cycle of digit 0.
REQ-013 SHALL have port pending  output  1  shadow holds a value not yet displayed.

Function
REQ-014 SHALL implement states IDLE, DWELL and GAP, plus a 2-bit digit index idx and a 16-bit cycle counter.
REQ-015 In IDLE with en=1, the block SHALL enter DWELL with idx=0 and counter=0 on the next cycle.
REQ-016 In DWELL, the block SHALL drive sel=one-hot(idx) and dp=dp_mask[idx].
REQ-017 After DWELL cycles in DWELL, the block SHALL enter GAP; when GAP=0 it SHALL go directly to DWELL with idx+1.
REQ-018 In GAP, the block SHALL drive sel=0 and dp=0 for GAP cycles, then enter DWELL with idx+1 (mod 4; 3 wraps to 0).
REQ-019 All outputs SHALL be registered, and nib SHALL equal active[4*idx+3:4*idx] in every state.
REQ-020 The frame length SHALL be 4*(DWELL+GAP) cycles, and frame_start SHALL pulse exactly once per frame.
REQ-021 On load, the block SHALL write value into the shadow register and set pending; when several loads occur in one frame, the last one SHALL be kept.
REQ-022 On each entry to DWELL with idx=0, the block SHALL copy shadow to active and clear pending if pending=1.
REQ-023 If load coincides with that transfer cycle, the block SHALL copy the value input directly to active and leave pending=0.
REQ-024 If en=0 in any state, the block SHALL enter IDLE on the next cycle with sel=0, dp=0, idx=0 and counter=0; active, shadow and pending SHALL be retained.
REQ-025 The displayed nibble SHALL never change mid-frame; active SHALL change only per REQ-022 and REQ-023.

Reset
REQ-026 With rst=1, the block SHALL set state=IDLE, idx=0, counter=0, active=0, shadow=0, pending=0, nib=0, sel=0, dp=0 and frame_start=0 on the next edge.
REQ-027 rst SHALL take priority over en and load, including when asserted mid-frame or mid-gap.

Configuration
REQ-028 With macro DIGI_LZ_BLANK_EN defined, the block SHALL force sel=0 and dp=0 during the dwell of any digit k>0 whose nibble and all higher nibbles of active are zero; dwell and gap timing SHALL be unchanged.
REQ-029 Digit 0 SHALL never be blanked.
REQ-030 Without DIGI_LZ_BLANK_EN defined, the block SHALL light all four digits unconditionally.

Verification (DWELL=4, GAP=2)
REQ-031 Reset; en=1; load 0x1234 -> frame_start every 24 cycles; sel/nib sequence is 0001/4 x4, 0000 x2, 0010/3 x4, 0000 x2, 0100/2 x4, 0000 x2, 1000/1 x4, 0000 x2.
REQ-032 Load 0xABCD during digit 1 of a frame showing 0x1234 -> rest of that frame shows 0x1234; pending=1 until the next frame_start, then 0xABCD is shown and pending=0.
REQ-033 Drop en during digit 2 dwell -> next cycle sel=0 in IDLE; re-raise en -> digit 0 dwell restarts with frame_start.
REQ-034 Macro defined, value 0x0050 -> digits 3 and 2 keep sel=0 during their dwell while digits 1 and 0 light; value 0x0000 -> only digit 0 lights; macro undefined -> all four light.
REQ-035 GAP=0 -> sel steps 0001->0010->0100->1000 with no zero cycle, and the frame is 16 cycles.
REQ-036 Assert rst for 1 cycle mid-gap after load 0x00FF -> all outputs 0 and pending=0; with en still 1, scanning restarts at digit 0 showing 0x0000.
